// File: rtl/instruction_fetch.sv
// Single-issue instruction fetch unit: BOOT/RUN/HALT sequencer with a one-entry fetch register.
// Optional performance counters (FetchCount, StallCount) are compiled in with macro FETCH_PERF_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 128
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] Address,
  input  logic [31:0] InstructionIn,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic        FetchValid,
  input  logic        FetchReady,
  output logic [31:0] FetchInstruction,
  output logic [31:0] FetchPC,
  output logic        Halted,
  output logic        FaultMisaligned
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_t      state;
  logic [31:0] pc;
  logic        pc_in_range;
  logic        slot_free;
  logic        target_misaligned;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  assign Address = pc;

  // Fetch conditions derived from the current state of the fetch register and PC.
  always_comb begin
    pc_in_range       = pc < MEM_LIMIT;
    slot_free         = !FetchValid || FetchReady;
    target_misaligned = is_misaligned(RedirectTarget);
  end

  // Sequencer: a redirect outranks everything; a misaligned one parks the unit in HALT.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state            <= BOOT;
      pc               <= RESET_PC;
      FetchValid       <= 1'b0;
      FetchInstruction <= 32'h0000_0000;
      FetchPC          <= 32'h0000_0000;
      Halted           <= 1'b0;
      FaultMisaligned  <= 1'b0;
    end else begin
      case (state)
        BOOT, RUN: begin
          if (RedirectValid) begin
            FetchValid <= 1'b0;
            if (target_misaligned) begin
              FaultMisaligned <= 1'b1;
              Halted          <= 1'b1;
              state           <= HALT;
            end else begin
              pc    <= RedirectTarget;
              state <= RUN;
            end
          end else if (state == BOOT) begin
            state <= RUN;
          end else if (!pc_in_range) begin
            // Out of memory: stop fetching but let the held instruction drain.
            state  <= HALT;
            Halted <= 1'b1;
            if (FetchReady) begin
              FetchValid <= 1'b0;
            end
          end else if (slot_free) begin
            FetchInstruction <= InstructionIn;
            FetchPC          <= pc;
            FetchValid       <= 1'b1;
            pc               <= pc + 32'd4;
          end
        end
        HALT: begin
          if (FetchReady) begin
            FetchValid <= 1'b0;
          end
        end
        default: begin
          state      <= HALT;
          Halted     <= 1'b1;
          FetchValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating handshake and stall counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      FetchCount <= 32'h0000_0000;
      StallCount <= 32'h0000_0000;
    end else begin
      if (FetchValid && FetchReady && (FetchCount != 32'hFFFF_FFFF)) begin
        FetchCount <= FetchCount + 32'd1;
      end
      if (FetchValid && !FetchReady && (StallCount != 32'hFFFF_FFFF)) begin
        StallCount <= StallCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// redirect/backpressure segments checked by a transaction-level scoreboard.
module tb_instruction_fetch;

  logic        Clk;
  logic        Reset;
  logic [31:0] Address;
  logic [31:0] InstructionIn;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;
  logic        FetchValid;
  logic        FetchReady;
  logic [31:0] FetchInstruction;
  logic [31:0] FetchPC;
  logic        Halted;
  logic        FaultMisaligned;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  int total;
  int passed;

  logic [31:0] mem [0:31];

  instruction_fetch #(.RESET_PC(32'h0000_0000), .MEM_BYTES(128)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Address          (Address),
    .InstructionIn    (InstructionIn),
    .RedirectValid    (RedirectValid),
    .RedirectTarget   (RedirectTarget),
    .FetchValid       (FetchValid),
    .FetchReady       (FetchReady),
    .FetchInstruction (FetchInstruction),
    .FetchPC          (FetchPC),
    .Halted           (Halted),
    .FaultMisaligned  (FaultMisaligned)
`ifdef FETCH_PERF_EN
    ,
    .FetchCount       (FetchCount),
    .StallCount       (StallCount)
`endif
  );

  assign InstructionIn = (Address < 32'd128) ? mem[Address[6:2]] : 32'hDEAD_BEEF;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  // Asserts Reset mid-cycle, confirms the asynchronous clear, releases on a falling edge.
  task automatic reset_dut();
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check_eq("rst_valid", {31'd0, FetchValid}, 32'd0);
    check_eq("rst_halted", {31'd0, Halted}, 32'd0);
    check_eq("rst_fault", {31'd0, FaultMisaligned}, 32'd0);
    check_eq("rst_fpc", FetchPC, 32'd0);
    check_eq("rst_finstr", FetchInstruction, 32'd0);
    check_eq("rst_addr", Address, 32'd0);
`ifdef FETCH_PERF_EN
    check_eq("rst_fcount", FetchCount, 32'd0);
    check_eq("rst_scount", StallCount, 32'd0);
`endif
    RedirectValid = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    logic [31:0] last_pc;
    int          n_seen;
    logic [31:0] exp_pc;
    logic        halt_m;
    logic        fault_m;
    logic        flush_m;
    logic        done;
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;

    total = 0;
    passed = 0;
    Reset = 1'b1;
    RedirectValid = 1'b0;
    RedirectTarget = 32'd0;
    FetchReady = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);

    #2;
    check_eq("por_valid", {31'd0, FetchValid}, 32'd0);
    check_eq("por_addr", Address, 32'd0);
    check_eq("por_halted", {31'd0, Halted}, 32'd0);

    // Sequential fetch from reset with decode always ready.
    @(negedge Clk);
    Reset = 1'b0;
    FetchReady = 1'b1;
    @(negedge Clk);
    check_eq("boot_valid", {31'd0, FetchValid}, 32'd0);
    check_eq("boot_addr", Address, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check_eq("seq_valid", {31'd0, FetchValid}, 32'd1);
      check_eq("seq_pc", FetchPC, 32'(4 * k));
      check_eq("seq_instr", FetchInstruction, 32'(k));
    end
    check_eq("seq_addr", Address, 32'd12);

    // Three-cycle stall at FetchPC=8.
    FetchReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check_eq("stall_pc", FetchPC, 32'd8);
      check_eq("stall_valid", {31'd0, FetchValid}, 32'd1);
      check_eq("stall_addr", Address, 32'd12);
      check_eq("stall_instr", FetchInstruction, 32'd2);
    end
    FetchReady = 1'b1;
    @(negedge Clk);
    check_eq("resume_pc", FetchPC, 32'd12);
    check_eq("resume_instr", FetchInstruction, 32'd3);

    // Aligned redirect flushes even with decode ready.
    RedirectValid = 1'b1;
    RedirectTarget = 32'h40;
    @(negedge Clk);
    RedirectValid = 1'b0;
    check_eq("redir_flush", {31'd0, FetchValid}, 32'd0);
    check_eq("redir_addr", Address, 32'h40);
    @(negedge Clk);
    check_eq("redir_valid", {31'd0, FetchValid}, 32'd1);
    check_eq("redir_pc", FetchPC, 32'h40);
    check_eq("redir_instr", FetchInstruction, 32'd16);

    // Run off the end of memory.
    last_pc = FetchPC;
    n_seen = 1;
    for (int c = 0; c < 40 && !Halted; c++) begin
      @(negedge Clk);
      if (FetchValid) begin
        last_pc = FetchPC;
        n_seen++;
      end
    end
    check_eq("end_halted", {31'd0, Halted}, 32'd1);
    check_eq("end_last_pc", last_pc, 32'h7C);
    check_eq("end_count", 32'(n_seen), 32'd16);
    check_eq("end_addr", Address, 32'h80);
    RedirectValid = 1'b1;
    RedirectTarget = 32'h0;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk);
      check_eq("halt_ign_addr", Address, 32'h80);
      check_eq("halt_ign_valid", {31'd0, FetchValid}, 32'd0);
      check_eq("halt_ign_halted", {31'd0, Halted}, 32'd1);
    end
    RedirectValid = 1'b0;

    // Reset while stalled discards the held instruction.
    reset_dut();
    FetchReady = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check_eq("pre_stall_valid", {31'd0, FetchValid}, 32'd1);
    @(negedge Clk);
    check_eq("mid_stall_pc", FetchPC, 32'd0);
    reset_dut();
    FetchReady = 1'b1;
    @(negedge Clk);
    check_eq("rst2_boot_valid", {31'd0, FetchValid}, 32'd0);
    @(negedge Clk);
    check_eq("rst2_valid", {31'd0, FetchValid}, 32'd1);
    check_eq("rst2_pc", FetchPC, 32'd0);

    // Misaligned redirect faults and parks the unit.
    @(negedge Clk);
    check_eq("pre_fault_addr", Address, 32'd8);
    RedirectValid = 1'b1;
    RedirectTarget = 32'h42;
    @(negedge Clk);
    check_eq("fault_flag", {31'd0, FaultMisaligned}, 32'd1);
    check_eq("fault_halted", {31'd0, Halted}, 32'd1);
    check_eq("fault_valid", {31'd0, FetchValid}, 32'd0);
    check_eq("fault_addr", Address, 32'd8);
    RedirectTarget = 32'h10;
    @(negedge Clk);
    RedirectValid = 1'b0;
    check_eq("fault_ign_addr", Address, 32'd8);
    check_eq("fault_ign_valid", {31'd0, FetchValid}, 32'd0);

`ifdef FETCH_PERF_EN
    // Five accepts followed by two stall cycles, then reset mid-stall.
    reset_dut();
    FetchReady = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    FetchReady = 1'b1;
    repeat (5) @(negedge Clk);
    FetchReady = 1'b0;
    repeat (2) @(negedge Clk);
    check_eq("perf_fetch", FetchCount, 32'd5);
    check_eq("perf_stall", StallCount, 32'd2);
    reset_dut();
`endif

    // Randomized segments: scoreboard tracks the next address decode should see.
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    for (int seg = 0; seg < 6; seg++) begin
      reset_dut();
      exp_pc  = 32'd0;
      halt_m  = 1'b0;
      fault_m = 1'b0;
      flush_m = 1'b0;
      done    = 1'b0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
        @(negedge Clk);
        check_eq("rnd_fault", {31'd0, FaultMisaligned}, {31'd0, fault_m});
        if (halt_m) begin
          check_eq("rnd_halt_state", {31'd0, Halted}, 32'd1);
          check_eq("rnd_halt_valid", {31'd0, FetchValid}, 32'd0);
        end
        if (flush_m) begin
          check_eq("rnd_flush", {31'd0, FetchValid}, 32'd0);
          flush_m = 1'b0;
        end
        if (Halted && !FetchValid) begin
          done = 1'b1;
        end else begin
          rdy   = ($urandom % 4) != 0;
          redir = !halt_m && (exp_pc < 32'h60) && (($urandom % 8) == 0);
          tgt   = 32'($urandom_range(0, 23)) * 32'd4;
          if (redir && (seg % 2 == 1) && (($urandom % 4) == 0)) tgt = tgt + 32'($urandom_range(1, 3));
          FetchReady     = rdy;
          RedirectValid  = redir || (halt_m && (($urandom % 3) == 0));
          RedirectTarget = tgt;
          if (redir) begin
            if (tgt[1:0] != 2'b00) begin
              fault_m = 1'b1;
              halt_m  = 1'b1;
            end else begin
              exp_pc  = tgt;
              flush_m = 1'b1;
            end
          end else if (FetchValid && rdy) begin
            check_eq("rnd_pc", FetchPC, exp_pc);
            check_eq("rnd_instr", FetchInstruction, mem[exp_pc[6:2]]);
            exp_pc = exp_pc + 32'd4;
          end
        end
      end
      RedirectValid = 1'b0;
      check_eq("rnd_seg_done", {31'd0, done}, 32'd1);
      if (!fault_m) check_eq("rnd_seg_end_pc", exp_pc, 32'h80);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter MEM_BYTES, default 128, meaning the instruction-memory size in bytes; it is the fetch limit.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port Address, output, 32 bits: byte address to the instruction memory, equal to the current PC.
REQ-006 SHALL have port InstructionIn, input, 32 bits: instruction word returned combinationally by the memory for Address.
REQ-007 SHALL have port RedirectValid, input, 1 bit: branch/jump redirect request.
REQ-008 SHALL have port RedirectTarget, input, 32 bits: redirect byte address.
REQ-009 SHALL have port FetchValid, output, 1 bit: FetchInstruction/FetchPC hold a valid instruction for decode.
REQ-010 SHALL have port FetchReady, input, 1 bit: decode accepts the current instruction.
REQ-011 SHALL have port FetchInstruction, output, 32 bits: registered instruction word.
REQ-012 SHALL have port FetchPC, output, 32 bits: byte address of FetchInstruction.
REQ-013 SHALL have port Halted, output, 1 bit: the fetch unit is in HALT.
REQ-014 SHALL have port FaultMisaligned, output, 1 bit: sticky flag set by a redirect whose target has bits [1:0] != 0.

Function
REQ-015 SHALL implement a 3-state FSM: BOOT, RUN, HALT; BOOT transitions to RUN unconditionally after one cycle; HALT is left only by Reset.
REQ-016 SHALL drive Address = PC combinationally in all states.
REQ-017 In RUN, with no redirect, PC < MEM_BYTES and (!FetchValid || FetchReady), SHALL load FetchInstruction<=InstructionIn, FetchPC<=PC, FetchValid<=1, PC<=PC+4; one-cycle latency from Address to FetchValid; one instruction per cycle sustained.
REQ-018 SHALL hold PC, FetchInstruction, FetchPC and FetchValid unchanged while FetchValid=1 and FetchReady=0.
REQ-019 SHALL give RedirectValid priority over every other event in BOOT and RUN: PC<=RedirectTarget, FetchValid<=0 (flush, even if FetchReady=1), no load that cycle.
REQ-020 A redirect with RedirectTarget[1:0]!=0 SHALL set FaultMisaligned=1, leave PC unchanged, clear FetchValid, and enter HALT.
REQ-021 When PC >= MEM_BYTES in RUN, SHALL perform no load and enter HALT; a pending valid instruction still drains (FetchValid clears on FetchReady).
REQ-022 SHALL ignore RedirectValid in HALT.
REQ-023 SHALL compute PC+4 modulo 2^32.
REQ-024 SHALL drive Halted=1 exactly while in HALT.

Reset
REQ-025 On Reset assertion, SHALL immediately and asynchronously set: state=BOOT, PC=RESET_PC, FetchValid=0, FetchInstruction=0, FetchPC=0, Halted=0, FaultMisaligned=0 (and both counters=0 if compiled in).
REQ-026 Reset mid-stall or mid-redirect SHALL discard the in-flight instruction; the first FetchValid=1 after deassertion appears 2 cycles later (BOOT + load) with FetchPC=RESET_PC.

Configuration
REQ-027 With macro FETCH_PERF_EN defined, SHALL add output FetchCount [31:0], counting cycles with FetchValid&&FetchReady, and output StallCount [31:0], counting cycles with FetchValid&&!FetchReady; both saturate at 32'hFFFF_FFFF.
REQ-028 Without FETCH_PERF_EN, these ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-029 Reset then FetchReady=1 held, memory word i = i -> FetchPC 0,4,8,... on consecutive cycles from cycle 2, FetchInstruction = 0,1,2,...
REQ-030 FetchReady=0 for 3 cycles while FetchValid=1 at FetchPC=8 -> outputs frozen at 8; Address=12 constant; resumes with 12 the cycle after Ready rises.
REQ-031 RedirectValid with target 0x40, FetchReady=1 -> FetchValid=0 that cycle; next cycle FetchPC=0x40.
REQ-032 RedirectValid with target 0x42 -> FaultMisaligned=1, Halted=1, FetchValid=0; later redirects have no effect.
REQ-033 Run sequentially to PC=0x80 (MEM_BYTES=128) -> last FetchPC=0x7C, then Halted=1, no further FetchValid.
REQ-034 With FETCH_PERF_EN: 5 accepts and 2 stall cycles -> FetchCount=5, StallCount=2; Reset asserted mid-stall -> both 0, FetchValid=0 at once.
